// File: rtl/serial_para.sv
// serial_para: serial-to-parallel frame assembler.
// Collects eight WIDTH-bit words from a serial stream into one frame. The first
// word of a frame lands on output_para_7 and the eighth on output_para_0.
// There are two frame stores: an assembly buffer and an output register.
// When the output register is still occupied at frame completion, the finished
// frame is held in the assembly buffer, and input is stalled until the consumer
// takes the current output.
module serial_para #(
  parameter int WIDTH = 18
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_serial,
  output logic [WIDTH-1:0] output_para_0,
  output logic [WIDTH-1:0] output_para_1,
  output logic [WIDTH-1:0] output_para_2,
  output logic [WIDTH-1:0] output_para_3,
  output logic [WIDTH-1:0] output_para_4,
  output logic [WIDTH-1:0] output_para_5,
  output logic [WIDTH-1:0] output_para_6,
  output logic [WIDTH-1:0] output_para_7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       word_count
);

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] asm_buf_r  [8];
  logic [WIDTH-1:0] out_lane_r [8];
  logic [WIDTH-1:0] frame_s    [8];
  logic [2:0]       count_r;
  logic [2:0]       lane_idx_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             accept_s;
  logic             last_word_s;
  logic             out_free_s;

  assign accept_s    = in_valid & in_ready_r;
  assign last_word_s = accept_s & (count_r == 3'd7);
  // The output register can take a new frame if it is empty or being drained now.
  assign out_free_s  = ~out_valid_r | out_ready;
  // Word n of a frame (0-based) belongs to lane 7-n.
  assign lane_idx_s  = 3'd7 - count_r;

  // Completed frame as seen on the 8th-word edge: lanes 7..1 are buffered, lane 0 is the live word.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      frame_s[i] = asm_buf_r[i];
    end
    frame_s[0] = input_serial;
  end

  // Control FSM with registered handshake outputs, frame buffer and output register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r     <= FILL;
      count_r     <= 3'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        asm_buf_r[i]  <= '0;
        out_lane_r[i] <= '0;
      end
    end else begin
      case (state_r)
        FILL: begin
          if (accept_s) begin
            asm_buf_r[lane_idx_s] <= input_serial;
            count_r               <= count_r + 3'd1;
          end
          if (last_word_s) begin
            if (out_free_s) begin
              out_lane_r  <= frame_s;
              out_valid_r <= 1'b1;
            end else begin
              // Output still owned by the consumer: park the frame in the buffer.
              state_r    <= STALL;
              in_ready_r <= 1'b0;
            end
          end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        STALL: begin
          // out_valid is always 1 here; the parked frame replaces the drained one.
          if (out_ready) begin
            out_lane_r  <= asm_buf_r;
            out_valid_r <= 1'b1;
            state_r     <= FILL;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= FILL;
          count_r     <= 3'd0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_r;
  assign out_valid     = out_valid_r;
  assign word_count    = count_r;
  assign output_para_0 = out_lane_r[0];
  assign output_para_1 = out_lane_r[1];
  assign output_para_2 = out_lane_r[2];
  assign output_para_3 = out_lane_r[3];
  assign output_para_4 = out_lane_r[4];
  assign output_para_5 = out_lane_r[5];
  assign output_para_6 = out_lane_r[6];
  assign output_para_7 = out_lane_r[7];

endmodule

// File: tb/tb_serial_para.sv
// tb_serial_para: directed bench for serial_para with a queue-based frame model
// checked on every cycle, plus hand-computed expectations per scenario.
module tb_serial_para;

  localparam int W = 18;

  logic         clock;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] input_serial;
  logic [W-1:0] op [8];
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   word_count;

  int total = 0;
  int bad   = 0;

  // Model state: words of the frame in progress, a parked frame, the visible frame.
  logic [W-1:0] part_q [$];
  bit           pend = 1'b0;
  logic [W-1:0] pend_f [8];
  bit           ov = 1'b0;
  logic [W-1:0] ofr [8];

  logic [W-1:0] par [8];
  logic [W-1:0] sh  [8];

  serial_para #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .input_serial (input_serial),
    .output_para_0(op[0]),
    .output_para_1(op[1]),
    .output_para_2(op[2]),
    .output_para_3(op[3]),
    .output_para_4(op[4]),
    .output_para_5(op[5]),
    .output_para_6(op[6]),
    .output_para_7(op[7]),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .word_count   (word_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs presented to the DUT.
  task automatic model_step();
    logic [W-1:0] tmp [8];
    if (!reset_n) begin
      part_q.delete();
      pend = 1'b0;
      ov   = 1'b0;
      for (int i = 0; i < 8; i++) ofr[i] = '0;
    end else if (pend) begin
      if (out_ready) begin
        ofr  = pend_f;
        pend = 1'b0;
      end
    end else begin
      if (in_valid) part_q.push_back(input_serial);
      if (part_q.size() == 8) begin
        for (int k = 0; k < 8; k++) tmp[7-k] = part_q[k];
        if (!ov || out_ready) begin
          ofr = tmp;
          ov  = 1'b1;
        end else begin
          pend_f = tmp;
          pend   = 1'b1;
        end
        part_q.delete();
      end else if (ov && out_ready) begin
        ov = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    check("in_ready", 32'(in_ready), 32'(!pend));
    check("out_valid", 32'(out_valid), 32'(ov));
    check("word_count", 32'(word_count), 32'(part_q.size()));
    for (int i = 0; i < 8; i++) begin
      check($sformatf("lane%0d", i), 32'(op[i]), 32'(ofr[i]));
    end
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge, compare at the next falling edge.
  task automatic tick(input logic v, input logic [W-1:0] d, input logic ordy, input logic rst);
    reset_n      = rst;
    in_valid     = v;
    input_serial = d;
    out_ready    = ordy;
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; input_serial = '0; out_ready = 1'b0;

    // Reset state
    tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_count", 32'(word_count), 32'd0);
    check("rst_lane3", 32'(op[3]), 32'd0);

    // Single frame 1..8
    for (int i = 1; i <= 8; i++) tick(1'b1, W'(i), 1'b1, 1'b1);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_l7", 32'(op[7]), 32'd1);
    check("single_l6", 32'(op[6]), 32'd2);
    check("single_l0", 32'(op[0]), 32'd8);
    check("single_count", 32'(word_count), 32'd0);
    tick(1'b0, '0, 1'b1, 1'b1);
    check("single_drain", 32'(out_valid), 32'd0);

    // Back-to-back 0..23
    for (int i = 0; i < 24; i++) begin
      tick(1'b1, W'(i), 1'b1, 1'b1);
      check("b2b_ready", 32'(in_ready), 32'd1);
      check("b2b_pulse", 32'(out_valid), 32'((i % 8) == 7));
    end
    check("b2b_l7", 32'(op[7]), 32'd16);
    check("b2b_l0", 32'(op[0]), 32'd23);
    tick(1'b0, '0, 1'b1, 1'b1);

    // Stall: 100..115 with out_ready low
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, W'(100 + i), 1'b0, 1'b1);
      if (i == 7) check("stall_f1_l7", 32'(op[7]), 32'd100);
    end
    check("stall_ready", 32'(in_ready), 32'd0);
    check("stall_hold_l7", 32'(op[7]), 32'd100);
    check("stall_hold_l0", 32'(op[0]), 32'd107);
    tick(1'b1, W'(999), 1'b0, 1'b1);
    tick(1'b1, W'(999), 1'b0, 1'b1);
    check("stall_ignore_l0", 32'(op[0]), 32'd107);
    tick(1'b0, '0, 1'b1, 1'b1);
    check("release_l7", 32'(op[7]), 32'd108);
    check("release_l0", 32'(op[0]), 32'd115);
    check("release_ready", 32'(in_ready), 32'd1);
    check("release_valid", 32'(out_valid), 32'd1);
    check("release_count", 32'(word_count), 32'd0);
    tick(1'b0, '0, 1'b1, 1'b1);

    // Output busy until the exact edge the next frame completes
    for (int i = 0; i < 16; i++) tick(1'b1, W'(200 + i), 1'(i == 15), 1'b1);
    check("swap_l7", 32'(op[7]), 32'd208);
    check("swap_l0", 32'(op[0]), 32'd215);
    check("swap_ready", 32'(in_ready), 32'd1);
    tick(1'b0, '0, 1'b1, 1'b1);

    // Sparse 5..12
    for (int w = 5; w <= 12; w++) begin
      tick(1'b1, W'(w), 1'b1, 1'b1);
      if (w == 12) begin
        check("sparse_valid", 32'(out_valid), 32'd1);
        check("sparse_l7", 32'(op[7]), 32'd5);
        check("sparse_l0", 32'(op[0]), 32'd12);
      end
      tick(1'b0, W'(777), 1'b1, 1'b1);
    end

    // Reset while stalled
    for (int i = 0; i < 16; i++) tick(1'b1, W'(300 + i), 1'b0, 1'b1);
    tick(1'b1, W'(1), 1'b0, 1'b0);
    check("stallrst_valid", 32'(out_valid), 32'd0);
    check("stallrst_ready", 32'(in_ready), 32'd1);
    check("stallrst_l7", 32'(op[7]), 32'd0);

    // Reset mid-frame
    for (int i = 0; i < 5; i++) tick(1'b1, W'(50 + i), 1'b1, 1'b1);
    tick(1'b0, '0, 1'b1, 1'b0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, W'(18'h3FFFF - k), 1'b1, 1'b1);
      if (k == 6) check("midrst_quiet", 32'(out_valid), 32'd0);
    end
    check("midrst_l7", 32'(op[7]), 32'h3FFFF);
    check("midrst_l0", 32'(op[0]), 32'h3FFF8);

    // Loopback through a parallel-to-serial shift register
    par[0] = 18'h00A11; par[1] = 18'h1B222; par[2] = 18'h2C333; par[3] = 18'h3D444;
    par[4] = 18'h0E555; par[5] = 18'h1F666; par[6] = 18'h20777; par[7] = 18'h31888;
    sh = par;
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, sh[7], 1'b1, 1'b1);
      for (int j = 7; j > 0; j--) sh[j] = sh[j-1];
    end
    for (int i = 0; i < 8; i++) check($sformatf("loop_lane%0d", i), 32'(op[i]), 32'(par[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
